// File: rtl/dc_genlik_cozucu.sv
`default_nettype none
// ============================================================================
//  Module   : dc_genlik_cozucu
//  Purpose  : JPEG DC amplitude decoder. Takes a DC category (SSSS), collects
//             that many serial amplitude bits (MSB first), applies the EXTEND
//             rule and accumulates the difference into the DC predictor.
//  Option   : DC_DOYMA_EN - when defined, the predictor addition saturates
//             instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module dc_genlik_cozucu #(
    parameter int DC_GENISLIK  = 12,
    parameter int KATEGORI_MAX = 11
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   kat_gecerli_i,
    input  logic [3:0]             kat_i,
    output logic                   kat_hazir_o,
    input  logic                   bit_gecerli_i,
    input  logic                   bit_i,
    output logic                   bit_hazir_o,
    input  logic                   ongorucu_sifirla_i,
    output logic [DC_GENISLIK-1:0] fark_o,
    output logic [DC_GENISLIK-1:0] dc_o,
    output logic                   cikis_gecerli_o,
    output logic                   hata_o
);

    // Amplitude register is as wide as the largest category. It must stay
    // narrower than DC_GENISLIK so EXTEND fits without truncation.
    localparam int         GEN_W   = KATEGORI_MAX;
    localparam logic [3:0] KAT_MAX = 4'(KATEGORI_MAX);

    typedef enum logic [1:0] {
        BOSTA     = 2'd0,
        BIT_TOPLA = 2'd1,
        GENISLET  = 2'd2,
        CIKIS     = 2'd3
    } durum_t;

    durum_t                 durum_q, durum_d;
    logic [3:0]             kat_q;
    logic [3:0]             sayac_q;
    logic [GEN_W-1:0]       genlik_q;
    logic [DC_GENISLIK-1:0] ongorucu_q;
    logic [DC_GENISLIK-1:0] fark_q;
    logic [DC_GENISLIK-1:0] dc_q;
    logic                   hata_q;

    logic                   w_kat_al;
    logic                   w_bit_al;
    logic                   w_tepe;
    logic [DC_GENISLIK-1:0] w_fark;
    logic [DC_GENISLIK-1:0] w_p;
    logic [DC_GENISLIK-1:0] w_dc;

    assign w_kat_al = kat_gecerli_i & kat_hazir_o;
    assign w_bit_al = bit_gecerli_i & bit_hazir_o;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q <= BOSTA;
        end else begin
            durum_q <= durum_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        durum_d         = durum_q;
        kat_hazir_o     = 1'b0;
        bit_hazir_o     = 1'b0;
        cikis_gecerli_o = 1'b0;
        case (durum_q)
            BOSTA: begin
                kat_hazir_o = 1'b1;
                if (w_kat_al) begin
                    // Category 0 and illegal categories carry no amplitude bits.
                    if ((kat_i == 4'd0) || (kat_i > KAT_MAX)) begin
                        durum_d = GENISLET;
                    end else begin
                        durum_d = BIT_TOPLA;
                    end
                end
            end
            BIT_TOPLA: begin
                bit_hazir_o = 1'b1;
                if (bit_gecerli_i && (sayac_q == 4'd1)) begin
                    durum_d = GENISLET;
                end
            end
            GENISLET: begin
                durum_d = CIKIS;
            end
            CIKIS: begin
                cikis_gecerli_o = 1'b1;
                durum_d         = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

    // EXTEND of the collected amplitude and predictor addition.
    always_comb begin
        // Top collected bit decides sign: 1 means positive difference.
        w_tepe = |(genlik_q & (GEN_W'(1) << (kat_q - 4'd1)));
        if ((kat_q == 4'd0) || (kat_q > KAT_MAX)) begin
            w_fark = '0;
        end else if (w_tepe) begin
            w_fark = DC_GENISLIK'(genlik_q);
        end else begin
            w_fark = DC_GENISLIK'(genlik_q) - (DC_GENISLIK'(1) << kat_q) + DC_GENISLIK'(1);
        end
        // A clear arriving in the same cycle wins over the stored predictor.
        w_p = ongorucu_sifirla_i ? '0 : ongorucu_q;
    end

`ifdef DC_DOYMA_EN
    logic [DC_GENISLIK:0] w_toplam;

    // Saturating add: one guard bit detects overflow in either direction.
    always_comb begin
        w_toplam = {w_p[DC_GENISLIK-1], w_p} + {w_fark[DC_GENISLIK-1], w_fark};
        if (w_toplam[DC_GENISLIK] != w_toplam[DC_GENISLIK-1]) begin
            w_dc = w_toplam[DC_GENISLIK] ? {1'b1, {(DC_GENISLIK-1){1'b0}}}
                                         : {1'b0, {(DC_GENISLIK-1){1'b1}}};
        end else begin
            w_dc = w_toplam[DC_GENISLIK-1:0];
        end
    end
`else
    // Plain modular add.
    always_comb begin
        w_dc = w_p + w_fark;
    end
`endif

    // Datapath: category latch, bit shifter, predictor and result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kat_q      <= '0;
            sayac_q    <= '0;
            genlik_q   <= '0;
            ongorucu_q <= '0;
            fark_q     <= '0;
            dc_q       <= '0;
            hata_q     <= 1'b0;
        end else begin
            if (w_kat_al) begin
                kat_q    <= kat_i;
                sayac_q  <= kat_i;
                genlik_q <= '0;
                if (kat_i > KAT_MAX) begin
                    hata_q <= 1'b1;
                end
            end
            if (w_bit_al) begin
                genlik_q <= {genlik_q[GEN_W-2:0], bit_i};
                sayac_q  <= sayac_q - 4'd1;
            end
            if (durum_q == GENISLET) begin
                fark_q     <= w_fark;
                dc_q       <= w_dc;
                ongorucu_q <= w_dc;
            end else if (ongorucu_sifirla_i) begin
                ongorucu_q <= '0;
            end
        end
    end

    assign fark_o = fark_q;
    assign dc_o   = dc_q;
    assign hata_o = hata_q;

endmodule
`default_nettype wire

// File: tb/tb_dc_genlik_cozucu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dc_genlik_cozucu
//  Purpose  : Directed self-checking bench for dc_genlik_cozucu with an
//             arithmetic reference model and per-cycle output comparison.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dc_genlik_cozucu;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         kat_gecerli_i = 1'b0;
    logic [3:0]   kat_i = '0;
    logic         kat_hazir_o;
    logic         bit_gecerli_i = 1'b0;
    logic         bit_i = 1'b0;
    logic         bit_hazir_o;
    logic         ongorucu_sifirla_i = 1'b0;
    logic [W-1:0] fark_o;
    logic [W-1:0] dc_o;
    logic         cikis_gecerli_o;
    logic         hata_o;

    dc_genlik_cozucu #(.DC_GENISLIK(W), .KATEGORI_MAX(11)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .kat_gecerli_i      (kat_gecerli_i),
        .kat_i              (kat_i),
        .kat_hazir_o        (kat_hazir_o),
        .bit_gecerli_i      (bit_gecerli_i),
        .bit_i              (bit_i),
        .bit_hazir_o        (bit_hazir_o),
        .ongorucu_sifirla_i (ongorucu_sifirla_i),
        .fark_o             (fark_o),
        .dc_o               (dc_o),
        .cikis_gecerli_o    (cikis_gecerli_o),
        .hata_o             (hata_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int f;
        int d;
    } bek_t;

    bek_t q[$];
    int   total = 0;
    int   bad = 0;
    int   pred = 0;
    bit   exp_hata = 1'b0;
    bit   basla = 1'b0;

    // Reference arithmetic.
    function automatic int sar(input int x);
        int m;
        m = x & ((1 << W) - 1);
        if (m >= (1 << (W - 1))) m = m - (1 << W);
        return m;
    endfunction

    function automatic int topla(input int a, input int b);
        int s;
        s = a + b;
`ifdef DC_DOYMA_EN
        if (s > (1 << (W - 1)) - 1) s = (1 << (W - 1)) - 1;
        if (s < -(1 << (W - 1))) s = -(1 << (W - 1));
        return s;
`else
        return sar(s);
`endif
    endfunction

    function automatic int extend(input int k, input int v);
        if (k == 0 || k > 11) return 0;
        if (v >= (1 << (k - 1))) return v;
        return v - (1 << k) + 1;
    endfunction

    task automatic chk(input string ad, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", ad, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (basla && !rst_i) begin
            total++;
            if (hata_o !== exp_hata) begin
                bad++;
                $display("FAIL hata_cycle: got %0b want %0b at cyc %0d", hata_o, exp_hata, cyc);
            end
            if (cikis_gecerli_o) begin
                bek_t e;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: got pulse at cyc %0d want none", cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc != e.c || int'($signed(fark_o)) != e.f || int'($signed(dc_o)) != e.d) begin
                        bad++;
                        $display("FAIL result: got cyc=%0d fark=%0d dc=%0d want cyc=%0d fark=%0d dc=%0d",
                                 cyc, $signed(fark_o), $signed(dc_o), e.c, e.f, e.d);
                    end
                end
            end
        end
    end

    task automatic drive_kat(input int k, output int n);
        int t;
        t = 0;
        @(negedge clk);
        kat_gecerli_i = 1'b1;
        kat_i = 4'(k);
        while (!kat_hazir_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            bad++;
            $display("FAIL kat_timeout: got no kat_hazir_o want accept of kat %0d", k);
        end
        n = cyc;
        @(posedge clk);
        #1;
        kat_gecerli_i = 1'b0;
        kat_i = 4'hF;
        if (k > 11) exp_hata = 1'b1;
    endtask

    task automatic send_bit(input bit b, output int n);
        int t;
        t = 0;
        @(negedge clk);
        bit_gecerli_i = 1'b1;
        bit_i = b;
        while (!bit_hazir_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            bad++;
            $display("FAIL bit_timeout: got no bit_hazir_o want bit accept");
        end
        n = cyc;
        @(posedge clk);
        #1;
        bit_gecerli_i = 1'b0;
        bit_i = ~b;
    endtask

    task automatic sifirla();
        @(negedge clk);
        ongorucu_sifirla_i = 1'b1;
        @(posedge clk);
        #1;
        ongorucu_sifirla_i = 1'b0;
        pred = 0;
    endtask

    // One complete DC: category, k amplitude bits of v (MSB first), optional
    // gap between bits, optional predictor clear during the extend cycle.
    task automatic islem(input int k, input int v, input int gap, input bit sg);
        int   n;
        int   f;
        int   p;
        bek_t e;
        drive_kat(k, n);
        if (k >= 1 && k <= 11) begin
            for (int i = k - 1; i >= 0; i--) begin
                send_bit(v[i], n);
                if (i > 0) repeat (gap) @(negedge clk);
            end
        end
        if (sg) begin
            ongorucu_sifirla_i = 1'b1;
            @(posedge clk);
            #1;
            ongorucu_sifirla_i = 1'b0;
        end
        f    = extend(k, v);
        p    = sg ? 0 : pred;
        pred = topla(p, f);
        e.c  = n + 2;
        e.f  = f;
        e.d  = pred;
        q.push_back(e);
        if (k == 0 || k > 11) begin
            repeat (4) begin
                @(negedge clk);
                chk("bit_hazir_idle", int'(bit_hazir_o), 0);
            end
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_fark", int'(fark_o), 0);
        chk("rst_dc", int'(dc_o), 0);
        chk("rst_hata", int'(hata_o), 0);
        chk("rst_pulse", int'(cikis_gecerli_o), 0);
        chk("rst_kat_hazir", int'(kat_hazir_o), 1);
        chk("rst_bit_hazir", int'(bit_hazir_o), 0);
        basla = 1'b1;

        sifirla();
        islem(3, 5, 2, 1'b0);
        chk("k3_101_fark", int'($signed(fark_o)), 5);
        chk("k3_101_dc", int'($signed(dc_o)), 5);

        islem(3, 2, 0, 1'b0);
        chk("k3_010_fark", int'($signed(fark_o)), -5);
        chk("k3_010_dc", int'($signed(dc_o)), 0);

        islem(0, 0, 0, 1'b0);
        chk("k0_fark", int'($signed(fark_o)), 0);
        chk("k0_dc", int'($signed(dc_o)), 0);

        sifirla();
        islem(11, 0, 0, 1'b0);
        chk("k11_a_fark", int'($signed(fark_o)), -2047);
        chk("k11_a_dc", int'($signed(dc_o)), -2047);
        islem(11, 0, 1, 1'b0);
        chk("k11_b_fark", int'($signed(fark_o)), -2047);
`ifdef DC_DOYMA_EN
        chk("k11_b_dc", int'($signed(dc_o)), -2048);
`else
        chk("k11_b_dc", int'($signed(dc_o)), 2);
`endif

        islem(12, 0, 0, 1'b0);
        chk("k12_hata", int'(hata_o), 1);
        chk("k12_fark", int'($signed(fark_o)), 0);

        // Reset in the middle of a kat=5 collection.
        drive_kat(5, n);
        send_bit(1'b1, n);
        send_bit(1'b0, n);
        rst_i    = 1'b1;
        exp_hata = 1'b0;
        pred     = 0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_kat_hazir", int'(kat_hazir_o), 1);
            chk("midrst_bit_hazir", int'(bit_hazir_o), 0);
        end
        chk("midrst_hata", int'(hata_o), 0);
        chk("midrst_fark", int'(fark_o), 0);
        chk("midrst_dc", int'(dc_o), 0);

        islem(1, 1, 0, 1'b0);
        chk("k1_1_fark", int'($signed(fark_o)), 1);
        chk("k1_1_dc", int'($signed(dc_o)), 1);

        islem(2, 3, 1, 1'b1);
        chk("k2_clr_fark", int'($signed(fark_o)), 3);
        chk("k2_clr_dc", int'($signed(dc_o)), 3);

        islem(1, 0, 0, 1'b0);
        chk("k1_0_fark", int'($signed(fark_o)), -1);
        chk("k1_0_dc", int'($signed(dc_o)), 2);

        islem(11, 2047, 0, 1'b0);
        chk("k11_max_fark", int'($signed(fark_o)), 2047);
`ifdef DC_DOYMA_EN
        chk("k11_max_dc", int'($signed(dc_o)), 2047);
`else
        chk("k11_max_dc", int'($signed(dc_o)), -2047);
`endif

        repeat (5) @(negedge clk);
        chk("pending_results", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
